mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and execute requests share a single memory port.
// Execute wins by default; fetch is forced through after STARVE_MAX consecutive losses.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        ex_req,
    input  logic        ex_we,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic [31:0] ex_rdata,
    output logic        ex_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_ex
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_M1    = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [3:0]  starve_cnt, starve_nx;
    logic        owner_ex, owner_nx;
    logic        we_q, we_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic [31:0] if_rdata_nx, ex_rdata_nx;
    logic        grant_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            owner_ex   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            ex_rdata   <= '0;
            if_valid   <= 1'b0;
            ex_valid   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            starve_cnt <= starve_nx;
            owner_ex   <= owner_nx;
            we_q       <= we_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            if_rdata   <= if_rdata_nx;
            ex_rdata   <= ex_rdata_nx;
            if_valid   <= (state_nx == RESP) && !owner_nx;
            ex_valid   <= (state_nx == RESP) && owner_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        starve_nx   = starve_cnt;
        owner_nx    = owner_ex;
        we_nx       = we_q;
        addr_nx     = addr_q;
        wdata_nx    = wdata_q;
        if_rdata_nx = if_rdata;
        ex_rdata_nx = ex_rdata;
        grant_ex    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || ex_req) begin
                    // Starvation counter only moves when both sides actually contend.
                    if (if_req && ex_req) begin
                        if (starve_cnt == STARVE_LIM) begin
                            grant_ex  = 1'b0;
                            starve_nx = '0;
                        end else begin
                            grant_ex  = 1'b1;
                            starve_nx = starve_cnt + 4'd1;
                        end
                    end else begin
                        grant_ex = ex_req;
                    end
                    owner_nx = grant_ex;
                    addr_nx  = grant_ex ? ex_addr : if_addr;
                    we_nx    = grant_ex && ex_we;
                    wdata_nx = grant_ex ? ex_wdata : '0;
                    cnt_nx   = LAT_M1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    if (!owner_ex)
                        if_rdata_nx = mem_rdata;
                    else if (!we_q)
                        ex_rdata_nx = mem_rdata;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign stall_if  = if_req && !if_valid;
    assign stall_ex  = ex_req && !ex_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-transaction vector table plus starvation,
// reset-abort and MEM_LAT=1 back-to-back sequences.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ex_req, ex_we;
    logic [31:0] if_addr, ex_addr, ex_wdata, mem_rdata;
    logic [31:0] if_rdata, ex_rdata, mem_addr, mem_wdata;
    logic        if_valid, ex_valid, mem_en, mem_we, stall_if, stall_ex;

    logic        if_req1, ex_req1, ex_we1;
    logic [31:0] if_addr1, ex_addr1, ex_wdata1, mem_rdata1;
    logic [31:0] if_rdata1, ex_rdata1, mem_addr1, mem_wdata1;
    logic        if_valid1, ex_valid1, mem_en1, mem_we1, stall_if1, stall_ex1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rdata(ex_rdata), .ex_valid(ex_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_ex(stall_ex)
    );

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1),
        .ex_req(ex_req1), .ex_we(ex_we1), .ex_addr(ex_addr1), .ex_wdata(ex_wdata1),
        .ex_rdata(ex_rdata1), .ex_valid(ex_valid1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_ex(stall_ex1)
    );

    typedef struct {
        logic        is_ex;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_ex_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   en_cnt = 0;
        int   lat = 0;
        int   other = 0;
        int   bad_mem = 0;
        int   bad_idle = 0;
        int   bad_stall = 0;
        logic seen = 1'b0;
        logic own, oth, own_stall;
        if (v.is_ex) begin
            ex_req = 1'b1; ex_we = v.we; ex_addr = v.addr; ex_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        mem_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                if (mem_addr !== v.addr || mem_we !== v.we) bad_mem++;
                if (v.we && mem_wdata !== v.wdata) bad_mem++;
                mem_rdata = (en_cnt == LAT) ? v.mrd : 32'hBAD0BAD0;
            end else begin
                if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) bad_idle++;
                mem_rdata = 32'hBAD0BAD0;
            end
            own       = v.is_ex ? ex_valid : if_valid;
            oth       = v.is_ex ? if_valid : ex_valid;
            own_stall = v.is_ex ? stall_ex : stall_if;
            if (own_stall !== !own) bad_stall++;
            if (oth) other++;
            if (own) begin
                lat  = c;
                seen = 1'b1;
                if_req = 1'b0;
                ex_req = 1'b0;
            end
        end
        check32($sformatf("v%0d latency", idx), 32'(lat), 32'(LAT + 1));
        check32($sformatf("v%0d mem_en cycles", idx), 32'(en_cnt), 32'(LAT));
        check32($sformatf("v%0d mem bus errors", idx), 32'(bad_mem), 32'd0);
        check32($sformatf("v%0d idle bus errors", idx), 32'(bad_idle), 32'd0);
        check32($sformatf("v%0d stall errors", idx), 32'(bad_stall), 32'd0);
        check32($sformatf("v%0d wrong-port valid", idx), 32'(other), 32'd0);
        @(negedge clk);
        check32($sformatf("v%0d if_rdata", idx), if_rdata, v.exp_if_rdata);
        check32($sformatf("v%0d ex_rdata", idx), ex_rdata, v.exp_ex_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_own[10];
        logic got_own[10];
        int   g, last, per_bad, both, en_cnt, lat, quiet_bad;
        logic exp_v;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h8C01_0000, 32'h8C01_0000, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 32'h8C01_0000, 32'h1111_2222};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_5555, 32'h8C01_0000, 32'h1111_2222};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0013, 32'h0000_0013, 32'h1111_2222};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_A5A5, 32'h0000_0013, 32'hA5A5_A5A5};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hA5A5_A5A5};
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        if_req = 0; ex_req = 0; ex_we = 0; if_addr = 0; ex_addr = 0; ex_wdata = 0; mem_rdata = 0;
        if_req1 = 0; ex_req1 = 0; ex_we1 = 0; if_addr1 = 0; ex_addr1 = 0; ex_wdata1 = 0; mem_rdata1 = 0;
        #12;
        check32("reset valids/mem ctl", {28'h0, if_valid, ex_valid, mem_en, mem_we}, 32'h0);
        check32("reset mem_addr", mem_addr, 32'h0);
        check32("reset if_rdata", if_rdata, 32'h0);
        check32("reset ex_rdata", ex_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Both requesters held: fetch should break through after four ex wins.
        if_req = 1'b1; if_addr = 32'h100;
        ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h200;
        mem_rdata = 32'h0;
        g = 0; last = -1; per_bad = 0; both = 0;
        got_own = '{default: 1'b0};
        for (int c = 0; c < 200 && g < 10; c++) begin
            @(negedge clk);
            if (ex_valid && if_valid) both++;
            if (ex_valid || if_valid) begin
                got_own[g] = ex_valid;
                if (last >= 0 && c - last != LAT + 2) per_bad++;
                last = c;
                g++;
                if (g == 10) begin
                    if_req = 1'b0;
                    ex_req = 1'b0;
                end
            end
        end
        if_req = 1'b0; ex_req = 1'b0;
        check32("starve grant count", 32'(g), 32'd10);
        check32("starve double valid", 32'(both), 32'd0);
        check32("starve period errors", 32'(per_bad), 32'd0);
        for (int i = 0; i < 10; i++)
            check32($sformatf("starve owner %0d (1=ex)", i), {31'h0, got_own[i]}, {31'h0, exp_own[i]});
        @(negedge clk);

        // Reset during the second ACCESS cycle abandons the fetch.
        if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h7777_7777;
        @(posedge clk);
        @(posedge clk);
        #2;
        check32("abort pre-reset mem_en", {31'h0, mem_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        check32("abort mem_en/we/valid", {28'h0, if_valid, ex_valid, mem_en, mem_we}, 32'h0);
        check32("abort mem_addr", mem_addr, 32'h0);
        check32("abort if_rdata", if_rdata, 32'h0);
        check32("abort ex_rdata", ex_rdata, 32'h0);
        quiet_bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (if_valid || ex_valid || mem_en) quiet_bad++;
        end
        check32("abort activity in reset", 32'(quiet_bad), 32'd0);
        mem_rdata = 32'h1234_5678;
        rst_n = 1'b1;
        en_cnt = 0; lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (if_valid) begin
                lat = c;
                check32("reserve if_rdata", if_rdata, 32'h1234_5678);
                if_req = 1'b0;
            end
        end
        check32("reserve latency", 32'(lat), 32'(LAT + 1));
        check32("reserve mem_en cycles", 32'(en_cnt), 32'(LAT));
        @(negedge clk);

        // MEM_LAT=1 with fetch held: valid every third cycle.
        if_req1 = 1'b1; if_addr1 = 32'h300; mem_rdata1 = 32'hCAFE_0001;
        #1;
        check32("lat1 c0 valid/stall", {30'h0, if_valid1, stall_if1}, 32'h1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            exp_v = (c % 3 == 2);
            check32($sformatf("lat1 c%0d valid/stall/en", c),
                    {29'h0, if_valid1, stall_if1, mem_en1},
                    {29'h0, exp_v, !exp_v, (c % 3 == 1)});
            if (c == 11) if_req1 = 1'b0;
        end
        check32("lat1 if_rdata", if_rdata1, 32'hCAFE_0001);
        check32("lat1 mem_addr idle", mem_addr1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
